ex_fwd_ctrl: RTL and testbench

Execute-stage operand forwarding and load-use hazard controller for the 5-stage pipeline. Sits directly downstream of the ID/EX pipeline buffer and consumes its register-address, operand, immediate and Op outputs. Keeps a two-deep history of the destination writes of the two older in-flight instructions (MEM and WB), and forwards results into the ALU operands. When a load result is not yet available it raises a one-cycle stall that holds IF/ID and ID/EX.

---
 rtl/ex_fwd_ctrl.sv | 121 ++++++++++++
 tb/tb_ex_fwd_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_fwd_ctrl.sv
// Execute-stage operand forwarding and load-use hazard control.
// Tracks the MEM (H1) and WB (H2) destination writes and steers ALU operands.
module ex_fwd_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [4:0]       rsd_i,
    input  logic [31:0]      rs1_data_i,
    input  logic [31:0]      rs2_data_i,
    input  logic [31:0]      imm_i,
    input  logic             Op_i,
    input  logic             RegWrite_i,
    input  logic             MemRead_i,
    input  logic             flush_i,
    input  logic [31:0]      ex_result_i,
    input  logic [31:0]      mem_rdata_i,
    output logic [31:0]      alu_a_o,
    output logic [31:0]      alu_b_o,
    output logic [31:0]      store_data_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
        logic        haz;
    } fwd_t;

    localparam logic [CNT_W-1:0] CntOne = 1;

    logic             v1_q, ld1_q, v2_q, ld2_q;
    logic [4:0]       rd1_q, rd2_q;
    logic [31:0]      d1_q, d2_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0] h2_data;
    fwd_t        fa, fb;
    logic        stall, cap;

    function automatic fwd_t resolve(
        input logic [4:0]  rs,
        input logic [31:0] rf,
        input logic        v1,
        input logic [4:0]  rd1,
        input logic [31:0] d1,
        input logic        ld1,
        input logic        v2,
        input logic [4:0]  rd2,
        input logic [31:0] h2d
    );
        fwd_t r;
        r.sel  = 2'b00;
        r.data = rf;
        r.haz  = 1'b0;
        if (rs != 5'd0) begin
            if (v1 && rd1 == rs) begin
                r.sel  = 2'b01;
                r.data = d1;
                r.haz  = ld1;
            end else if (v2 && rd2 == rs) begin
                r.sel  = 2'b10;
                r.data = h2d;
            end
        end
        return r;
    endfunction

    always_comb begin
        h2_data = ld2_q ? mem_rdata_i : d2_q;
        fa = resolve(rs1_i, rs1_data_i, v1_q, rd1_q, d1_q, ld1_q, v2_q, rd2_q, h2_data);
        fb = resolve(rs2_i, rs2_data_i, v1_q, rd1_q, d1_q, ld1_q, v2_q, rd2_q, h2_data);
        // An rs2 hazard is ignored only for a load whose B operand is the immediate.
        stall = valid_i && !flush_i && (fa.haz || (fb.haz && !(Op_i && MemRead_i)));
        cap   = valid_i && !flush_i && !stall && RegWrite_i && (rsd_i != 5'd0);
    end

    assign alu_a_o      = fa.data;
    assign store_data_o = fb.data;
    assign alu_b_o      = Op_i ? imm_i : fb.data;
    assign fwd_a_o      = fa.sel;
    assign fwd_b_o      = fb.sel;
    assign stall_o      = stall;
    assign stall_cnt_o  = cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            v1_q  <= 1'b0;
            rd1_q <= 5'd0;
            d1_q  <= 32'd0;
            ld1_q <= 1'b0;
            v2_q  <= 1'b0;
            rd2_q <= 5'd0;
            d2_q  <= 32'd0;
            ld2_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            v2_q  <= v1_q;
            rd2_q <= rd1_q;
            d2_q  <= d1_q;
            ld2_q <= ld1_q;
            // A stalled or killed instruction leaves a bubble in H1.
            v1_q  <= cap;
            ld1_q <= cap && MemRead_i;
            if (cap) begin
                rd1_q <= rsd_i;
                d1_q  <= ex_result_i;
            end
            if (stall && cnt_q != '1) begin
                cnt_q <= cnt_q + CntOne;
            end
        end
    end

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// Directed and randomized check of ex_fwd_ctrl against a history-list model
// of the two older in-flight instructions.
module tb_ex_fwd_ctrl;

    localparam int CW = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid, op, rw, mr, flush;
    logic [4:0]    rs1, rs2, rsd;
    logic [31:0]   rs1_data, rs2_data, imm, ex_result, mem_rdata;
    logic [31:0]   alu_a, alu_b, store_data;
    logic [1:0]    fwd_a, fwd_b;
    logic          stall;
    logic [CW-1:0] stall_cnt;

    ex_fwd_ctrl #(.CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid),
        .rs1_i(rs1), .rs2_i(rs2), .rsd_i(rsd),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .imm_i(imm),
        .Op_i(op), .RegWrite_i(rw), .MemRead_i(mr), .flush_i(flush),
        .ex_result_i(ex_result), .mem_rdata_i(mem_rdata),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .store_data_o(store_data),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_o(stall), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v;
        bit [4:0]  rd;
        bit [31:0] d;
        bit        ld;
    } ent_t;

    ent_t hist[$];    // [0] = instruction now in MEM, [1] = instruction now in WB
    int   cnt_m;
    int   errors = 0;
    int   checks = 0;

    bit [1:0]  e_fa, e_fb;
    bit [31:0] e_a, e_b, e_sd;
    bit        e_stall, e_cap;

    task automatic model_reset();
        ent_t z;
        z = '{v: 1'b0, rd: 5'd0, d: 32'd0, ld: 1'b0};
        hist = {z, z};
        cnt_m = 0;
    endtask

    task automatic resolve(input bit [4:0] rs, input bit [31:0] rf,
                           output bit [1:0] sel, output bit [31:0] data, output bit haz);
        sel = 2'd0; data = rf; haz = 1'b0;
        if (rs != 0) begin
            if (hist[0].v && hist[0].rd == rs) begin
                sel = 2'd1; data = hist[0].d; haz = hist[0].ld;
            end else if (hist[1].v && hist[1].rd == rs) begin
                sel = 2'd2; data = hist[1].ld ? mem_rdata : hist[1].d;
            end
        end
    endtask

    task automatic model_eval();
        bit ha, hb;
        resolve(rs1, rs1_data, e_fa, e_a, ha);
        resolve(rs2, rs2_data, e_fb, e_sd, hb);
        e_b     = op ? imm : e_sd;
        e_stall = valid && !flush && (ha || (hb && !(op && mr)));
        e_cap   = valid && !flush && !e_stall && rw && rsd != 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        model_eval();
        chk({tag, ".alu_a"}, alu_a, e_a);
        chk({tag, ".alu_b"}, alu_b, e_b);
        chk({tag, ".store"}, store_data, e_sd);
        chk({tag, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, e_fa});
        chk({tag, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, e_fb});
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
        chk({tag, ".cnt"}, {{(32-CW){1'b0}}, stall_cnt}, cnt_m);
    endtask

    task automatic clk_step();
        ent_t n;
        model_eval();
        @(posedge clk);
        if (e_cap) n = '{v: 1'b1, rd: rsd, d: ex_result, ld: mr};
        else       n = '{v: 1'b0, rd: hist[0].rd, d: hist[0].d, ld: 1'b0};
        hist.push_front(n);
        void'(hist.pop_back());
        if (e_stall && cnt_m < CNT_MAX) cnt_m++;
        #1;
    endtask

    task automatic set_ins(input bit v, input bit [4:0] a, input bit [4:0] b, input bit [4:0] d,
                           input bit o, input bit w, input bit m, input bit [31:0] r);
        valid = v; rs1 = a; rs2 = b; rsd = d; op = o; rw = w; mr = m; ex_result = r;
        rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
        flush = 1'b0;
    endtask

    initial begin
        set_ins(1, 3, 4, 0, 1, 0, 0, 0);
        mem_rdata = 32'h0;
        model_reset();
        #12 rst = 1'b1;
        @(posedge clk); #1;

        // Reset state: regfile data and imm pass straight through.
        check_all("reset");
        chk("reset.alu_a_rf", alu_a, rs1_data);
        chk("reset.alu_b_imm", alu_b, imm);

        // Back-to-back ALU dependency.
        set_ins(1, 1, 2, 5, 0, 1, 0, 32'h11); check_all("add_x5"); clk_step();
        set_ins(1, 5, 2, 9, 0, 1, 0, 32'h33); check_all("sub_x5");
        chk("b2b.fwd_a", {30'd0, fwd_a}, 32'd1);
        chk("b2b.alu_a", alu_a, 32'h11);
        clk_step();

        // Distance-2 dependency on rs2 with register operand.
        set_ins(1, 1, 2, 6, 0, 1, 0, 32'h22); check_all("wr_x6"); clk_step();
        set_ins(1, 1, 2, 10, 0, 1, 0, 32'h44); check_all("indep"); clk_step();
        set_ins(1, 3, 6, 11, 0, 1, 0, 32'h55); check_all("rd_x6");
        chk("d2.fwd_b", {30'd0, fwd_b}, 32'd2);
        chk("d2.alu_b", alu_b, 32'h22);
        clk_step();

        // Load-use: exactly one stall, then forward from mem_rdata.
        set_ins(1, 1, 2, 7, 1, 1, 1, 32'h100); check_all("lw_x7"); clk_step();
        set_ins(1, 7, 2, 12, 0, 1, 0, 32'h66); check_all("lu_stall");
        chk("lu.stall", {31'd0, stall}, 32'd1);
        clk_step();
        mem_rdata = 32'hDEADBEEF;
        check_all("lu_after");
        chk("lu.alu_a", alu_a, 32'hDEADBEEF);
        chk("lu.stall0", {31'd0, stall}, 32'd0);
        chk("lu.cnt", {{(32-CW){1'b0}}, stall_cnt}, 32'd1);
        clk_step();

        // x0 writes never forward.
        set_ins(1, 1, 2, 0, 0, 1, 0, 32'h77); check_all("wr_x0"); clk_step();
        set_ins(1, 0, 0, 13, 0, 1, 0, 32'h88); check_all("rd_x0");
        chk("x0.fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("x0.alu_a", alu_a, rs1_data);
        clk_step();

        // H1 wins over H2 on the same register.
        set_ins(1, 1, 2, 8, 0, 1, 0, 32'h2); check_all("x8_old"); clk_step();
        set_ins(1, 1, 2, 8, 0, 1, 0, 32'h1); check_all("x8_new"); clk_step();
        set_ins(1, 8, 2, 14, 0, 1, 0, 32'h99); check_all("x8_rd");
        chk("prio.fwd_a", {30'd0, fwd_a}, 32'd1);
        chk("prio.alu_a", alu_a, 32'h1);
        clk_step();

        // Flush beats a load-use hazard and leaves H1 empty.
        set_ins(1, 1, 2, 7, 1, 1, 1, 32'h200); check_all("lw_x7b"); clk_step();
        set_ins(1, 7, 2, 12, 0, 1, 0, 32'hAA); flush = 1'b1; check_all("flush");
        chk("flush.stall", {31'd0, stall}, 32'd0);
        clk_step();
        set_ins(1, 1, 12, 15, 0, 1, 0, 32'hBB); check_all("post_flush");
        chk("flush.h1_dead", {30'd0, fwd_b}, 32'd0);
        clk_step();

        // Asynchronous reset while stalling.
        set_ins(1, 1, 2, 7, 1, 1, 1, 32'h300); check_all("lw_x7c"); clk_step();
        set_ins(1, 7, 2, 12, 0, 1, 0, 32'hCC); check_all("pre_rst");
        chk("rst.stall1", {31'd0, stall}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst.stall0", {31'd0, stall}, 32'd0);
        chk("rst.cnt0", {{(32-CW){1'b0}}, stall_cnt}, 32'd0);
        chk("rst.fwd_a", {30'd0, fwd_a}, 32'd0);
        model_reset();
        #1 rst = 1'b1;
        check_all("after_rst");
        clk_step();

        // Saturation of the stall counter.
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            set_ins(1, 1, 2, 7, 1, 1, 1, 32'h400 + i); check_all("sat_lw"); clk_step();
            set_ins(1, 7, 2, 12, 0, 1, 0, 32'h500 + i); check_all("sat_use"); clk_step();
        end
        chk("sat.cnt", {{(32-CW){1'b0}}, stall_cnt}, CNT_MAX);

        // Randomized traffic with a small register pool to force collisions.
        for (int i = 0; i < 600; i++) begin
            set_ins($urandom_range(9, 0) != 0, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                    5'($urandom_range(7, 0)), 1'($urandom), 1'($urandom_range(3, 0) != 0),
                    1'($urandom_range(2, 0) == 0), $urandom);
            flush = ($urandom_range(9, 0) == 0);
            mem_rdata = $urandom;
            check_all("rand");
            clk_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
